// File: rtl/mac_pkg.sv
// mac_pkg: shared types, Booth decode and saturation helpers for mac_booth_sat
package mac_pkg;
  typedef enum logic [1:0] {IDLE, MULT, ACC} mac_state_t;
  typedef enum logic [2:0] {PP_ZERO, PP_POS1, PP_POS2, PP_NEG1, PP_NEG2} booth_op_t;
  localparam int SAT_W = 128;
  function automatic booth_op_t booth_decode(input logic [2:0] t);
    case (t)
      3'b001, 3'b010: return PP_POS1;
      3'b011:         return PP_POS2;
      3'b100:         return PP_NEG2;
      3'b101, 3'b110: return PP_NEG1;
      default:        return PP_ZERO;
    endcase
  endfunction
  function automatic logic [SAT_W-1:0] sat_max(input int w);
    return (SAT_W'(1) << (w - 1)) - SAT_W'(1);
  endfunction
  function automatic logic [SAT_W-1:0] sat_min(input int w);
    return SAT_W'(1) << (w - 1);
  endfunction
endpackage

// File: rtl/booth_r4_iter.sv
// booth_r4_iter: iterative radix-4 Booth signed multiplier, one digit per cycle
module booth_r4_iter
  import mac_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [DATA_WIDTH-1:0]     a_in,
  input  logic [DATA_WIDTH-1:0]     b_in,
  output logic                      done,
  output logic [2*DATA_WIDTH-1:0]   product
);
  localparam int PW = 2*DATA_WIDTH + 2;
  localparam int N  = DATA_WIDTH/2;
  localparam int CW = $clog2(N);
  logic [PW-1:0]       mcand, pp, term;
  logic [DATA_WIDTH:0] mplr;
  logic [CW-1:0]       cnt;
  logic                busy;
  booth_op_t           op;
  // mcand carries the 4^i weighting by shifting left two bits per digit
  always_comb begin
    op   = booth_decode(mplr[2:0]);
    term = op == PP_POS1 ? mcand :
           op == PP_POS2 ? mcand << 1 :
           op == PP_NEG1 ? -mcand :
           op == PP_NEG2 ? -(mcand << 1) : '0;
    done = busy && cnt == CW'(N-1);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand <= '0;
      pp    <= '0;
      mplr  <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
    end else if (start) begin
      mcand <= {{(PW-DATA_WIDTH){a_in[DATA_WIDTH-1]}}, a_in};
      pp    <= '0;
      mplr  <= {b_in, 1'b0};
      cnt   <= '0;
      busy  <= 1'b1;
    end else if (busy) begin
      pp    <= pp + term;
      mcand <= mcand << 2;
      mplr  <= {{2{mplr[DATA_WIDTH]}}, mplr[DATA_WIDTH:2]};
      cnt   <= cnt + 1'b1;
      busy  <= ~done;
    end
  end
  assign product = pp[2*DATA_WIDTH-1:0];
endmodule

// File: rtl/mac_booth_sat.sv
// mac_booth_sat: handshaked Booth MAC with saturating or wrapping accumulator and sticky overflow
module mac_booth_sat
  import mac_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 40
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] a_in,
  input  logic [DATA_WIDTH-1:0] b_in,
  input  logic                  clr_acc,
  input  logic                  sat_en,
  output logic [ACC_WIDTH-1:0]  acc_out,
  output logic                  out_valid,
  output logic                  ovf_flag
);
  localparam logic [ACC_WIDTH-1:0] ACC_MAX = ACC_WIDTH'(sat_max(ACC_WIDTH));
  localparam logic [ACC_WIDTH-1:0] ACC_MIN = ACC_WIDTH'(sat_min(ACC_WIDTH));
  mac_state_t               state, state_nxt;
  logic                     accept, done, clr_q, sat_q, ovf;
  logic [2*DATA_WIDTH-1:0]  product;
  logic [ACC_WIDTH:0]       sum;
  logic [ACC_WIDTH-1:0]     acc_nxt;
  booth_r4_iter #(.DATA_WIDTH(DATA_WIDTH)) u_mult (
    .clk     (clk),
    .rst     (rst),
    .start   (accept),
    .a_in    (a_in),
    .b_in    (b_in),
    .done    (done),
    .product (product)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end
  always_comb begin
    state_nxt = state == IDLE ? (accept ? MULT : IDLE) :
                state == MULT ? (done ? ACC : MULT) : IDLE;
  end
  always_comb begin
    in_ready = state == IDLE;
  end
  assign accept = in_valid && in_ready;
  // one guard bit above the accumulator exposes signed overflow
  always_comb begin
    sum     = (clr_q ? '0 : {acc_out[ACC_WIDTH-1], acc_out})
            + {{(ACC_WIDTH+1-2*DATA_WIDTH){product[2*DATA_WIDTH-1]}}, product};
    ovf     = sum[ACC_WIDTH] ^ sum[ACC_WIDTH-1];
    acc_nxt = ovf && sat_q ? (sum[ACC_WIDTH] ? ACC_MIN : ACC_MAX) : sum[ACC_WIDTH-1:0];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_out   <= '0;
      ovf_flag  <= 1'b0;
      out_valid <= 1'b0;
      clr_q     <= 1'b0;
      sat_q     <= 1'b0;
    end else begin
      out_valid <= state == ACC;
      if (accept) begin
        clr_q <= clr_acc;
        sat_q <= sat_en;
      end
      if (state == ACC) begin
        acc_out  <= acc_nxt;
        ovf_flag <= (ovf_flag & ~clr_q) | ovf;
      end else if (state == IDLE && clr_acc && !in_valid) begin
        acc_out  <= '0;
        ovf_flag <= 1'b0;
      end
    end
  end
endmodule
